// File: rtl/serial_frame_receiver_if.sv
// serial_frame_receiver_if
//   Groups the serial-side inputs and the word-side outputs of the frame
//   receiver into a single bundle.
//   en        : bit-sample enable tick
//   din       : serial line, idles high
//   data      : last correctly framed word
//   valid     : one-cycle pulse, data just updated
//   frame_err : one-cycle pulse, stop bit sampled low
//   busy      : receiver is inside a frame (DATA or STOP)
//   master drives the serial side; slave is the receiver.
interface serial_frame_receiver_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             din;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             frame_err;
  logic             busy;

  modport master (
    output en, din,
    input  data, valid, frame_err, busy
  );

  modport slave (
    input  en, din,
    output data, valid, frame_err, busy
  );
endinterface

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Deserialises a start + WIDTH data + stop bit frame sampled on enabled
//   rising clk edges and presents the word in parallel with a one-cycle
//   valid strobe, or a one-cycle frame_err strobe on a bad stop bit.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_frame_receiver_if.slave (en, din in; data, valid,
//           frame_err, busy out)
//
//   state | meaning
//   IDLE  | waiting for a start bit (din=0 on an enabled edge)
//   DATA  | shifting in WIDTH data bits
//   STOP  | sampling the stop bit, then back to IDLE
module serial_frame_receiver #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_frame_receiver_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Strobes default low every cycle so they clear even while en is low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (bus.en) begin
      unique case (state_q)
        IDLE: begin
          if (!bus.din) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          if (LSB_FIRST) shift_d = {bus.din, shift_q[WIDTH-1:1]};
          else           shift_d = {shift_q[WIDTH-2:0], bus.din};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = STOP;
        end
        STOP: begin
          if (bus.din) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_serial_frame_receiver.sv
module tb_serial_frame_receiver;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic din = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_frame_receiver_if #(.WIDTH(W)) if_l ();
  serial_frame_receiver_if #(.WIDTH(W)) if_m ();

  assign if_l.en  = en;
  assign if_l.din = din;
  assign if_m.en  = en;
  assign if_m.din = din;

  serial_frame_receiver #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .bus(if_l)
  );
  serial_frame_receiver #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .bus(if_m)
  );

  typedef struct packed {
    logic         err;
    logic [W-1:0] data;
    logic [31:0]  cyc;
  } exp_t;

  exp_t         q_l[$];
  exp_t         q_m[$];
  logic [W-1:0] good_l = '0;
  logic [W-1:0] good_m = '0;
  logic         exp_busy = 1'b0;
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [W-1:0] rev(logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction

  task automatic tick(logic e, logic d);
    en  = e;
    din = d;
    @(posedge clk);
    #1;
  endtask

  // mode 0: en every clk, 1: en every 4th clk, 2: random en gaps
  task automatic put_bit(logic d, int mode);
    int gaps;
    gaps = (mode == 1) ? 3 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
    for (int i = 0; i < gaps; i++) tick(1'b0, 1'($urandom));
    tick(1'b1, d);
  endtask

  // tx[i] is the i-th data bit on the wire
  task automatic send_frame(logic [W-1:0] tx, logic stop, int mode);
    put_bit(1'b0, mode);
    exp_busy = 1'b1;
    for (int i = 0; i < W; i++) put_bit(tx[i], mode);
    put_bit(stop, mode);
    exp_busy = 1'b0;
    if (stop) begin
      good_l = tx;
      good_m = rev(tx);
    end
    q_l.push_back('{err: !stop, data: good_l, cyc: 32'(cyc)});
    q_m.push_back('{err: !stop, data: good_m, cyc: 32'(cyc)});
  endtask

  task automatic check_zero(string tag);
    chk({tag, " lsb data"}, 32'(if_l.data), 0);
    chk({tag, " lsb valid"}, 32'(if_l.valid), 0);
    chk({tag, " lsb frame_err"}, 32'(if_l.frame_err), 0);
    chk({tag, " lsb busy"}, 32'(if_l.busy), 0);
    chk({tag, " msb data"}, 32'(if_m.data), 0);
    chk({tag, " msb valid"}, 32'(if_m.valid), 0);
    chk({tag, " msb frame_err"}, 32'(if_m.frame_err), 0);
    chk({tag, " msb busy"}, 32'(if_m.busy), 0);
  endtask

  task automatic mon(int idx, logic v, logic e, logic [W-1:0] d, logic b);
    exp_t  x;
    string p;
    int    qs;
    p  = (idx != 0) ? "msb" : "lsb";
    qs = (idx != 0) ? q_m.size() : q_l.size();
    chk({p, " busy"}, 32'(b), 32'(exp_busy));
    chk({p, " data_hold"}, 32'(d), 32'((idx != 0) ? good_m : good_l));
    chk({p, " valid_and_err"}, 32'(v & e), 0);
    if (v || e) begin
      if (qs == 0) begin
        n_checks++;
        $display("FAIL %s unexpected_pulse: got valid=%0b frame_err=%0b, expected no pulse (cycle %0d)",
                 p, v, e, cyc);
      end else begin
        x = (idx != 0) ? q_m.pop_front() : q_l.pop_front();
        chk({p, " pulse_kind"}, 32'({v, e}), 32'({~x.err, x.err}));
        chk({p, " pulse_cycle"}, 32'(cyc), x.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, if_l.valid, if_l.frame_err, if_l.data, if_l.busy);
      mon(1, if_m.valid, if_m.frame_err, if_m.data, if_m.busy);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] tx;
    logic         stop;
    int           mode;

    rst_n = 1'b0;
    #2;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);

    send_frame(8'hA5, 1'b1, 0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);

    send_frame(8'hA5, 1'b0, 0);
    tick(1'b1, 1'b1);

    send_frame(8'h3C, 1'b1, 0);
    send_frame(8'hC3, 1'b1, 0);
    tick(1'b1, 1'b1);

    send_frame(8'h5A, 1'b1, 1);
    repeat (3) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);

    // abort after the 4th data bit of 0xF0 (remaining bits are all 1)
    tick(1'b1, 1'b0);
    exp_busy = 1'b1;
    repeat (4) tick(1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    exp_busy = 1'b0;
    good_l = '0;
    good_m = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) tick(1'b1, 1'b1);
    send_frame(8'h81, 1'b1, 0);
    tick(1'b1, 1'b1);

    send_frame(8'h0F, 1'b1, 0);
    tick(1'b1, 1'b1);

    for (int n = 0; n < 40; n++) begin
      tx   = W'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      mode = int'($urandom_range(0, 2));
      send_frame(tx, stop, mode);
      repeat ($urandom_range(0, 3)) tick(1'($urandom), 1'b1);
    end

    repeat (4) tick(1'b1, 1'b1);
    chk("lsb pending_expectations", 32'(q_l.size()), 0);
    chk("msb pending_expectations", 32'(q_m.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
